hazard_stall_ctrl: RTL

//  Pipeline sequencer for the 5-stage stall-only MIPS core (no forwarding).

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/hazard_cmp.sv | 27 ++
 rtl/hazard_stall_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the stall-only pipeline sequencer: state encoding,
// the hard-wired zero register and the default register-address width.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;
    localparam int REG_ZERO       = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HAZ      = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// One ID source register compared against the EX and MEM writers.
// Register 0 never matches because writes to it are discarded.
module hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src,
    input  logic              ex_valid,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              match
);

    logic src_nz;
    logic ex_hit;
    logic mem_hit;

    assign src_nz  = (src != REG_AW'(REG_ZERO));
    assign ex_hit  = ex_valid  && ex_wreg  && (ex_rd  == src);
    assign mem_hit = mem_valid && mem_wreg && (mem_rd == src);
    assign match   = src_nz && (ex_hit || mem_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage stall-only core: RAW stalls, data-memory
// wait and taken-branch flush. Optional statistics under HAZARD_STATS_EN.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEFAULT,
    parameter int MAX_STALL = 3,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_valid,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              dmem_busy,
    input  logic              branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              be_freeze,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stat_stalls,
    output logic [CNT_W-1:0]  stat_flushes
);

    localparam int SC_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    logic             rs_match;
    logic             rt_match;
    logic             hazard;
    pipe_state_t      state;
    pipe_state_t      nxt;
    logic [SC_W-1:0]  stall_cnt;

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs (
        .src       (id_rs),
        .ex_valid  (ex_valid),
        .ex_wreg   (ex_wreg),
        .ex_rd     (ex_rd),
        .mem_valid (mem_valid),
        .mem_wreg  (mem_wreg),
        .mem_rd    (mem_rd),
        .match     (rs_match)
    );

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rt (
        .src       (id_rt),
        .ex_valid  (ex_valid),
        .ex_wreg   (ex_wreg),
        .ex_rd     (ex_rd),
        .mem_valid (mem_valid),
        .mem_wreg  (mem_wreg),
        .mem_rd    (mem_rd),
        .match     (rt_match)
    );

    assign hazard = id_valid && ((id_use_rs && rs_match) || (id_use_rt && rt_match));

    // Branch operands are not ready while stalled, so a taken branch only
    // flushes when neither memory wait nor a RAW hazard is present.
    always_comb begin
        nxt         = RUN;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        be_freeze   = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (dmem_busy) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            be_freeze = 1'b1;
            nxt       = MEM_WAIT;
        end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            nxt         = HAZ;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // The stall counter survives MEM_WAIT so a memory wait cannot hide a
    // hazard stall that is running too long; only a return to RUN clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == HAZ) begin
                if (int'(stall_cnt) < MAX_STALL)
                    stall_cnt <= stall_cnt + 1'b1;
                if (int'(stall_cnt) + 1 >= MAX_STALL)
                    stall_timeout <= 1'b1;
            end else if ((nxt == RUN) && (state != RUN)) begin
                stall_cnt <= '0;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stalls  <= '0;
            stat_flushes <= '0;
        end else begin
            if (!pc_en)
                stat_stalls <= stat_stalls + 1'b1;
            if (ifid_flush)
                stat_flushes <= stat_flushes + 1'b1;
        end
    end
`else
    assign stat_stalls  = '0;
    assign stat_flushes = '0;
`endif

endmodule
